// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding and oversampling constants for the UART receiver
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] MID_TICK = 4'd7;
  localparam logic [3:0] LAST_TICK = 4'd15;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: STAGES-deep synchronizer for an idle-high asynchronous line
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk_in or posedge rst)
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 16x-oversampled UART receiver with valid/ack handshake.
// Optional parity stage and ports are enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 rx_clk,
  input  logic                 rx_serial,
  input  logic                 rx_ack,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
  output logic                 parity_err,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  state_e                 state_q, state_d;
  logic [3:0]             os_cnt_q, os_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d, rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   rx_s, done, accept;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d, parity_err_q, parity_err_d;
`endif

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_in(clk_in),
    .rst   (rst),
    .d_i   (rx_serial),
    .q_o   (rx_s)
  );

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
`endif
    done      = 1'b0;
    if (rx_clk) begin
      case (state_q)
        IDLE: if (!rx_s) begin
          state_d  = START;
          os_cnt_d = '0;
        end
        START: if (os_cnt_q == MID_TICK) begin
          state_d   = rx_s ? IDLE : DATA;
          os_cnt_d  = '0;
          bit_cnt_d = '0;
        end else os_cnt_d = os_cnt_q + 4'd1;
        // Shifting in from the MSB leaves the first-received bit at the LSB.
        DATA: if (os_cnt_q == LAST_TICK) begin
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          os_cnt_d  = '0;
          bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt_q == LAST_BIT) state_d = PARITY;
`else
          if (bit_cnt_q == LAST_BIT) state_d = STOP;
`endif
        end else os_cnt_d = os_cnt_q + 4'd1;
`ifdef UART_RX_PARITY_EN
        PARITY: if (os_cnt_q == LAST_TICK) begin
          par_d    = rx_s;
          os_cnt_d = '0;
          state_d  = STOP;
        end else os_cnt_d = os_cnt_q + 4'd1;
`endif
        STOP: if (os_cnt_q == LAST_TICK) begin
          done    = 1'b1;
          state_d = IDLE;
        end else os_cnt_d = os_cnt_q + 4'd1;
        default: state_d = IDLE;
      endcase
    end
  end

  // A completion coinciding with an ack is accepted rather than counted as overrun.
  assign accept      = done && (!rx_valid_q || rx_ack);
  assign rx_valid_d  = accept ? 1'b1 : (rx_ack ? 1'b0 : rx_valid_q);
  assign rx_data_d   = accept ? shift_q : rx_data_q;
  assign frame_err_d = accept ? ~rx_s : frame_err_q;
  assign overrun_d   = (done && !accept) ? 1'b1 : ((rx_ack && rx_valid_q) ? 1'b0 : overrun_q);
`ifdef UART_RX_PARITY_EN
  assign parity_err_d = accept ? (par_q ^ (^shift_q) ^ parity_odd) : parity_err_q;
`endif

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed self-checking bench for uart_rx_frame, rx_clk every 4 clk_in cycles
module tb_uart_rx_frame;
  localparam int DB = 8;
  logic          clk_in = 1'b0, rst = 1'b0, rx_clk = 1'b0, rx_serial = 1'b1, rx_ack = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, overrun, busy;
  int            errors = 0, checks = 0, div = 0;
`ifdef UART_RX_PARITY_EN
  logic          parity_odd = 1'b0, parity_err;
`endif

  uart_rx_frame #(.DATA_BITS(DB), .SYNC_STAGES(2)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .rx_clk   (rx_clk),
    .rx_serial(rx_serial),
    .rx_ack   (rx_ack),
`ifdef UART_RX_PARITY_EN
    .parity_odd(parity_odd),
    .parity_err(parity_err),
`endif
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    rx_clk = (div == 0);
    div = (div + 1) % 4;
  end

  task automatic send_bit(input logic b);
    rx_serial = b;
    repeat (64) @(negedge clk_in);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par) rx_serial = 1'b1;
`endif
    send_bit(stop_bit);
    rx_serial = 1'b1;
  endtask

  task automatic do_ack();
    @(negedge clk_in);
    rx_ack = 1'b1;
    @(negedge clk_in);
    rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({rx_data, rx_valid, frame_err, overrun, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b fe=%b ov=%b busy=%b expected all 0",
               rx_data, rx_valid, frame_err, overrun, busy);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic test_basic();
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_pre_valid: got %b expected 0", rx_valid); end
    send_frame(8'hA5, 1'b1, 1'b0);
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", rx_valid); end
    checks++;
    if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", rx_data); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b expected 0", frame_err); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", busy); end
    do_ack();
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_ack: got %b expected 0", rx_valid); end
  endtask

  task automatic test_glitch();
    rx_serial = 1'b0;
    repeat (12) @(negedge clk_in);
    rx_serial = 1'b1;
    repeat (4) @(negedge clk_in);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi: got %b expected 1", busy); end
    repeat (40) @(negedge clk_in);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo: got %b expected 0", busy); end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", rx_valid); end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 1'b0);
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL ferr_valid: got %b expected 1", rx_valid); end
    checks++;
    if (rx_data !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h expected 3c", rx_data); end
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", frame_err); end
    send_bit(1'b1);
    send_bit(1'b1);
    do_ack();
    send_frame(8'h01, 1'b1, 1'b0);
    checks++;
    if (rx_data !== 8'h01) begin errors++; $display("FAIL ferr_next_data: got %h expected 01", rx_data); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_cleared: got %b expected 0", frame_err); end
    do_ack();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    checks++;
    if (rx_data !== 8'h11) begin errors++; $display("FAIL b2b_data: got %h expected 11", rx_data); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", rx_valid); end
    do_ack();
    checks++;
    if ({rx_valid, overrun} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_ack: got v=%b ov=%b expected 0 0", rx_valid, overrun);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    repeat (20) @(negedge clk_in);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_pre: got %b expected 1", busy); end
    rst = 1'b1;
    @(negedge clk_in);
    checks++;
    if ({rx_valid, busy, frame_err, overrun} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_outputs: got v=%b busy=%b fe=%b ov=%b expected 0", rx_valid, busy, frame_err, overrun);
    end
    rst = 1'b0;
    repeat (64 * 8) @(negedge clk_in);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_word: got %b expected 0", rx_valid); end
    send_frame(8'h5A, 1'b1, 1'b0);
    checks++;
    if (rx_data !== 8'h5A || rx_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midrst_5a: got data=%h v=%b ov=%b expected 5a 1 0", rx_data, rx_valid, overrun);
    end
    do_ack();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0);
    checks++;
    if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_bad: got %b expected 1", parity_err); end
    do_ack();
    send_frame(8'h07, 1'b1, 1'b1);
    checks++;
    if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_good: got %b expected 0", parity_err); end
    do_ack();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
